mod_counter_chain: RTL and testbench

- Parametrised cascade of NUM_DIGITS modulo-N digit counters, each with its own modulus; carry/borrow ripples through the chain in the same cycle.
- Replaces hand-wired chains of single-digit counters in the stopwatch datapath, e.g. a MM:SS display with digit moduli 10/6/10/6.
- Adds up/down counting, synchronous clear, parallel load with clamping, per-digit carry flags and a registered whole-chain wrap pulse.

---
 rtl/mod_counter_chain.sv | 107 ++++++++++
 tb/tb_mod_counter_chain.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_chain.sv
// Cascade of per-digit modulo-N counters with same-cycle carry/borrow ripple,
// clear, clamped parallel load and a registered whole-chain wrap pulse.
// Optional lap capture register is enabled by defining LAP_CAPTURE_EN.
module mod_counter_chain #(
  parameter int                      NUM_DIGITS   = 4,
  parameter logic [4*NUM_DIGITS-1:0] MOD_VALUES   = 16'h6A6A,
  parameter logic [4*NUM_DIGITS-1:0] RESET_VALUES = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  input  logic                      increment,
  input  logic                      down,
  output logic [4*NUM_DIGITS-1:0]   count,
  output logic [NUM_DIGITS-1:0]     digit_carry,
  output logic                      rollover
`ifdef LAP_CAPTURE_EN
  ,
  input  logic                      lap,
  output logic [4*NUM_DIGITS-1:0]   lap_count
`endif
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("mod_counter_chain: NUM_DIGITS must be 1..8");
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_param_check
    if (MOD_VALUES[4*g +: 4] < 4'd2) begin : g_bad_mod
      $error("mod_counter_chain: modulus field below 2");
    end
    if (RESET_VALUES[4*g +: 4] >= MOD_VALUES[4*g +: 4]) begin : g_bad_reset
      $error("mod_counter_chain: reset value field not below its modulus");
    end
  end

  logic                    step_en;
  logic                    chain;
  logic                    at_edge;
  logic [3:0]              cur_digit;
  logic [3:0]              cur_mod;
  logic [3:0]              ld_field;
  logic [4*NUM_DIGITS-1:0] stepped;
  logic [4*NUM_DIGITS-1:0] clamped;
  logic [4*NUM_DIGITS-1:0] count_next;
  logic [NUM_DIGITS-1:0]   carry_int;

  // chain tracks whether every lower digit sits at its wrap point, so the
  // whole ripple resolves combinationally and lands on one edge.
  always_comb begin
    step_en   = increment && !reset && !clear && !load;
    stepped   = count;
    carry_int = '0;
    chain     = 1'b1;
    cur_digit = '0;
    cur_mod   = '0;
    at_edge   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_digit = count[4*i +: 4];
      cur_mod   = MOD_VALUES[4*i +: 4];
      at_edge   = down ? (cur_digit == 4'd0) : (cur_digit == cur_mod - 4'd1);
      if (step_en && chain) begin
        carry_int[i] = at_edge;
        if (down) stepped[4*i +: 4] = at_edge ? cur_mod - 4'd1 : cur_digit - 4'd1;
        else      stepped[4*i +: 4] = at_edge ? 4'd0 : cur_digit + 4'd1;
      end
      chain = chain && at_edge;
    end
  end

  always_comb begin
    clamped  = '0;
    ld_field = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ld_field = load_value[4*i +: 4];
      clamped[4*i +: 4] = (ld_field >= MOD_VALUES[4*i +: 4]) ?
                          MOD_VALUES[4*i +: 4] - 4'd1 : ld_field;
    end
  end

  always_comb begin
    if (reset || clear) count_next = RESET_VALUES;
    else if (load)      count_next = clamped;
    else if (increment) count_next = stepped;
    else                count_next = count;
  end

  assign digit_carry = carry_int;

  // carry_int is already zero under reset/clear/load, so the pulse is
  // dropped on those edges without extra gating.
  always_ff @(posedge clk) begin
    count <= count_next;
    if (reset) rollover <= 1'b0;
    else       rollover <= carry_int[NUM_DIGITS-1];
  end

`ifdef LAP_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset)    lap_count <= '0;
    else if (lap) lap_count <= count_next;
  end
`endif

endmodule

// File: tb/tb_mod_counter_chain.sv
// Self-checking bench for mod_counter_chain (default 10/6/10/6 chain):
// directed vector table, full-cycle count run and randomized model checks.
module tb_mod_counter_chain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        increment = 1'b0;
  logic        down = 1'b0;
  logic        lap_in = 1'b0;
  logic [15:0] count;
  logic [3:0]  digit_carry;
  logic        rollover;
`ifdef LAP_CAPTURE_EN
  logic [15:0] lap_count;
`endif

  mod_counter_chain dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .increment   (increment),
    .down        (down),
    .count       (count),
    .digit_carry (digit_carry),
    .rollover    (rollover)
`ifdef LAP_CAPTURE_EN
    ,
    .lap         (lap_in),
    .lap_count   (lap_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: the chain is a mixed-radix number in 0..3599.
  int mods[4]   = '{10, 6, 10, 6};
  int weight[4] = '{1, 10, 60, 600};
  int prefix[4] = '{10, 60, 600, 3600};
  int total = 3600;
  int m_v = 0;
  logic m_roll = 1'b0;
  logic [15:0] m_lap = '0;

  function automatic int to_int(input logic [15:0] p);
    int v = 0;
    for (int i = 0; i < 4; i++) v += int'(p[4*i +: 4]) * weight[i];
    return v;
  endfunction

  function automatic logic [15:0] to_packed(input int v);
    logic [15:0] p = '0;
    for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'((v / weight[i]) % mods[i]);
    return p;
  endfunction

  function automatic int clamp_int(input logic [15:0] lv);
    int v = 0;
    int f;
    for (int i = 0; i < 4; i++) begin
      f = int'(lv[4*i +: 4]);
      if (f > mods[i] - 1) f = mods[i] - 1;
      v += f * weight[i];
    end
    return v;
  endfunction

  function automatic logic [3:0] model_carry(input logic r, c, l, inc, dn);
    logic [3:0] car = '0;
    if (inc && !r && !c && !l)
      for (int i = 0; i < 4; i++)
        car[i] = dn ? (m_v % prefix[i] == 0) : (m_v % prefix[i] == prefix[i] - 1);
    return car;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  logic [3:0] last_carry;
  logic [3:0] exp_carry;

  // Drive one cycle, sample the combinational carry mid-cycle, then the
  // registered outputs just after the edge; the model advances in step.
  task automatic apply(input logic r, c, l, input logic [15:0] lv,
                       input logic inc, dn, lp);
    reset = r; clear = c; load = l; load_value = lv;
    increment = inc; down = dn; lap_in = lp;
    exp_carry = model_carry(r, c, l, inc, dn);
    @(negedge clk);
    last_carry = digit_carry;
    @(posedge clk);
    if (r || c) begin
      m_v = 0; m_roll = 1'b0;
    end else if (l) begin
      m_v = clamp_int(lv); m_roll = 1'b0;
    end else if (inc) begin
      m_roll = exp_carry[3];
      m_v = dn ? (m_v + total - 1) % total : (m_v + 1) % total;
    end else begin
      m_roll = 1'b0;
    end
    if (r) m_lap = '0;
    else if (lp) m_lap = to_packed(m_v);
    #1;
  endtask

  typedef struct {
    logic        r, c, l;
    logic [15:0] lv;
    logic        inc, dn;
    logic [15:0] e_count;
    logic [3:0]  e_carry;
    logic        e_roll;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, c, l, input logic [15:0] lv,
                              input logic inc, dn, input logic [15:0] ec,
                              input logic [3:0] ecar, input logic er);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.lv = lv; v.inc = inc; v.dn = dn;
    v.e_count = ec; v.e_carry = ecar; v.e_roll = er;
    return v;
  endfunction

  int pulses;

  initial begin
    // r c l  load     inc dn  count    carry    roll
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 4'b0000, 0)); // reset state
    vecs.push_back(mk(0, 0, 1, 16'hF7C3, 0, 0, 16'h5753, 4'b0000, 0)); // clamped load
    vecs.push_back(mk(0, 0, 1, 16'h1234, 1, 0, 16'h1234, 4'b0000, 0)); // load beats increment
    vecs.push_back(mk(0, 1, 1, 16'h5555, 1, 0, 16'h0000, 4'b0000, 0)); // clear beats load
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 16'h5959, 4'b1111, 1)); // full borrow
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h5959, 4'b0000, 0)); // hold, pulse ends
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 4'b1111, 1)); // full carry
    vecs.push_back(mk(0, 0, 1, 16'h5958, 0, 0, 16'h5958, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'h5959, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 4'b0000, 0)); // reset on wrap edge
    vecs.push_back(mk(0, 0, 1, 16'h0129, 0, 0, 16'h0129, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'h0130, 4'b0001, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 16'h0129, 4'b0001, 0)); // direction flip
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'h0130, 4'b0001, 0));
    vecs.push_back(mk(0, 0, 1, 16'h5959, 0, 0, 16'h5959, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 4'b0000, 0)); // clear on wrap edge

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k].r, vecs[k].c, vecs[k].l, vecs[k].lv, vecs[k].inc, vecs[k].dn, 1'b0);
      check($sformatf("vec%0d count", k), count, vecs[k].e_count);
      check($sformatf("vec%0d carry", k), {12'h0, last_carry}, {12'h0, vecs[k].e_carry});
      check($sformatf("vec%0d rollover", k), {15'h0, rollover}, {15'h0, vecs[k].e_roll});
    end

    // Full cycle of the chain counting up from reset.
    apply(1, 0, 0, 16'h0000, 0, 0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 3601; k++) begin
      apply(0, 0, 0, 16'h0000, 1, 0, 1'b0);
      check("run count", count, to_packed(m_v));
      check("run carry", {12'h0, last_carry}, {12'h0, exp_carry});
      check("run rollover", {15'h0, rollover}, {15'h0, m_roll});
      if (rollover) pulses++;
      if (k == 3598) check("run pre-wrap count", count, 16'h5959);
      if (k == 3599) check("run wrap carry", {12'h0, last_carry}, 16'h000F);
    end
    check("run rollover pulses", 16'(pulses), 16'd1);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 2000; k++) begin
      apply($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 8, 16'($urandom_range(0, 65535)),
            $urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 10);
      check("rand count", count, to_packed(m_v));
      check("rand carry", {12'h0, last_carry}, {12'h0, exp_carry});
      check("rand rollover", {15'h0, rollover}, {15'h0, m_roll});
`ifdef LAP_CAPTURE_EN
      check("rand lap_count", lap_count, m_lap);
`endif
    end

`ifdef LAP_CAPTURE_EN
    apply(1, 0, 0, 16'h0000, 0, 0, 1'b0);
    check("lap reset", lap_count, 16'h0000);
    apply(0, 0, 1, 16'h0129, 0, 0, 1'b0);
    apply(0, 0, 0, 16'h0000, 1, 0, 1'b1);
    check("lap capture", lap_count, 16'h0130);
    check("lap count", count, 16'h0130);
    apply(0, 1, 0, 16'h0000, 0, 0, 1'b0);
    check("lap after clear", lap_count, 16'h0130);
    check("count after clear", count, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
